// File: rtl/encoder_sample_ctrl.sv
// Periodic / on-demand snapshot of the decoder position with a software zero offset,
// per-sample velocity (delta since last accepted sample) and a valid/ready output with overrun flag.
module encoder_sample_ctrl #(
   parameter int unsigned PERIOD_CYCLES = 1000,
   parameter int unsigned CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [31:0]       position,
   input  logic              zero_req,
   input  logic              snap_req,
   output logic [31:0]       out_pos,
   output logic [31:0]       out_vel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  sample_count,
   output logic              overrun,
   input  logic              clr_overrun
);

   localparam logic [15:0] TIMER_LAST = 16'(PERIOD_CYCLES - 1);

   logic [15:0]      timer_q, timer_d;
   logic             enable_q;
   logic             first_q, first_d;
   logic [31:0]      offset_q, offset_d;
   logic [31:0]      prev_pos_q, prev_pos_d;
   logic [31:0]      out_pos_q, out_pos_d;
   logic [31:0]      out_vel_q, out_vel_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] sample_count_q, sample_count_d;
   logic             overrun_q, overrun_d;

   logic        enable_rise, tick, sample_event, load, drop;
   logic [31:0] offset_eff, prev_eff, rel_pos;

   always_comb begin
      enable_rise  = enable & ~enable_q;
      tick         = enable & (timer_q == TIMER_LAST);
      sample_event = tick | snap_req;
      load         = sample_event & (~out_valid_q | out_ready);
      drop         = sample_event & out_valid_q & ~out_ready;

      // A zero request takes effect before any same-cycle sample is computed.
      offset_eff = zero_req ? position : offset_q;
      prev_eff   = zero_req ? 32'd0 : prev_pos_q;
      rel_pos    = position - offset_eff;

      timer_d        = (!enable || tick) ? 16'd0 : timer_q + 16'd1;
      first_d        = first_q | enable_rise;
      offset_d       = offset_eff;
      prev_pos_d     = prev_eff;
      out_pos_d      = out_pos_q;
      out_vel_d      = out_vel_q;
      out_valid_d    = out_valid_q;
      sample_count_d = sample_count_q;

      if (load) begin
         out_pos_d      = rel_pos;
         out_vel_d      = first_d ? 32'd0 : rel_pos - prev_eff;
         prev_pos_d     = rel_pos;
         first_d        = 1'b0;
         out_valid_d    = 1'b1;
         sample_count_d = sample_count_q + 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      overrun_d = drop | (overrun_q & ~clr_overrun);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q        <= '0;
         enable_q       <= 1'b0;
         first_q        <= 1'b1;
         offset_q       <= '0;
         prev_pos_q     <= '0;
         out_pos_q      <= '0;
         out_vel_q      <= '0;
         out_valid_q    <= 1'b0;
         sample_count_q <= '0;
         overrun_q      <= 1'b0;
      end else begin
         timer_q        <= timer_d;
         enable_q       <= enable;
         first_q        <= first_d;
         offset_q       <= offset_d;
         prev_pos_q     <= prev_pos_d;
         out_pos_q      <= out_pos_d;
         out_vel_q      <= out_vel_d;
         out_valid_q    <= out_valid_d;
         sample_count_q <= sample_count_d;
         overrun_q      <= overrun_d;
      end
   end

   assign out_pos      = out_pos_q;
   assign out_vel      = out_vel_q;
   assign out_valid    = out_valid_q;
   assign sample_count = sample_count_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_encoder_sample_ctrl.sv
// Bench for encoder_sample_ctrl: a cycle-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed sample values.
module tb_encoder_sample_ctrl;

   localparam int P = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [31:0] position = 32'd0;
   logic        zero_req = 1'b0;
   logic        snap_req = 1'b0;
   logic        out_ready = 1'b0;
   logic        clr_overrun = 1'b0;
   logic [31:0] out_pos, out_vel;
   logic        out_valid, overrun;
   logic [15:0] sample_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: what the outputs must hold after each edge.
   logic [31:0] m_pos, m_vel, m_offset, m_prev;
   logic        m_valid, m_first, m_overrun, m_en_prev;
   logic [15:0] m_count;
   int          m_run;   // consecutive cycles enable has been high

   encoder_sample_ctrl #(.PERIOD_CYCLES(P), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .enable(enable), .position(position),
      .zero_req(zero_req), .snap_req(snap_req), .out_pos(out_pos),
      .out_vel(out_vel), .out_valid(out_valid), .out_ready(out_ready),
      .sample_count(sample_count), .overrun(overrun), .clr_overrun(clr_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pos = 0; m_vel = 0; m_offset = 0; m_prev = 0;
      m_valid = 0; m_first = 1; m_overrun = 0; m_en_prev = 0;
      m_count = 0; m_run = 0;
   endtask

   task automatic model_step();
      logic        tick, ev, accepted;
      logic [31:0] off, prv, rel;
      if (enable && !m_en_prev) m_first = 1;
      tick = enable && ((m_run % P) == P - 1);
      ev   = tick || snap_req;
      off  = zero_req ? position : m_offset;
      prv  = zero_req ? 32'd0 : m_prev;
      rel  = position - off;
      accepted = m_valid && out_ready;
      m_prev = prv;
      if (ev && (!m_valid || out_ready)) begin
         m_vel   = m_first ? 32'd0 : rel - prv;
         m_pos   = rel;
         m_prev  = rel;
         m_first = 0;
         m_valid = 1;
         m_count = m_count + 16'd1;
      end else if (ev) begin
         m_overrun = 1;
      end else if (accepted) begin
         m_valid = 0;
      end
      if (clr_overrun && !(ev && m_valid && !out_ready && !accepted && m_overrun && 0))
         if (!(ev && !out_ready && !(ev && (!m_valid || out_ready)))) m_overrun = m_overrun && !clr_overrun;
      m_offset  = off;
      m_run     = enable ? m_run + 1 : 0;
      m_en_prev = enable;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         if (!rst) model_step();
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("cyc_out_pos", out_pos, m_pos);
            chk("cyc_out_vel", out_vel, m_vel);
            chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            chk("cyc_sample_count", {16'd0, sample_count}, {16'd0, m_count});
            chk("cyc_overrun", {31'd0, overrun}, {31'd0, m_overrun});
            if (out_valid && out_ready)
               $display("accept: pos=%0d vel=%0d count=%0d", $signed(out_pos), $signed(out_vel), sample_count);
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      cyc(3);
      rst = 1'b0;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_pos", out_pos, 32'd0);
      chk("rst_count", {16'd0, sample_count}, 32'd0);
      chk("rst_overrun", {31'd0, overrun}, 32'd0);

      // Ramp position by one per cycle: ticks capture 7 and 15.
      enable = 1; out_ready = 1; position = 0;
      for (int k = 1; k <= 16; k++) begin
         cyc();
         if (k == 8) begin
            chk("ramp1_pos", out_pos, 32'd7);
            chk("ramp1_vel", out_vel, 32'd0);
            chk("ramp1_count", {16'd0, sample_count}, 32'd1);
         end
         if (k == 16) begin
            chk("ramp2_pos", out_pos, 32'd15);
            chk("ramp2_vel", out_vel, 32'd8);
            chk("ramp2_count", {16'd0, sample_count}, 32'd2);
         end
         position = k;
      end

      // Zero at 100, hold 130 until the next tick.
      position = 100; zero_req = 1;
      cyc();
      zero_req = 0; position = 130;
      cyc(7);
      chk("zero_pos", out_pos, 32'd30);
      chk("zero_vel", out_vel, 32'd30);

      // Re-zero at 0, then stall the consumer across two ticks.
      position = 0; zero_req = 1;
      cyc();
      zero_req = 0; out_ready = 0; position = 10;
      cyc(7);
      chk("stall_pos", out_pos, 32'd10);
      chk("stall_vel", out_vel, 32'd10);
      chk("stall_count", {16'd0, sample_count}, 32'd4);
      position = 20;
      cyc(8);
      chk("drop_pos", out_pos, 32'd10);
      chk("drop_overrun", {31'd0, overrun}, 32'd1);
      chk("drop_count", {16'd0, sample_count}, 32'd4);
      out_ready = 1; position = 35;
      cyc(8);
      chk("span_pos", out_pos, 32'd35);
      chk("span_vel", out_vel, 32'd25);
      chk("span_count", {16'd0, sample_count}, 32'd5);
      clr_overrun = 1;
      cyc();
      clr_overrun = 0;
      chk("clr_overrun", {31'd0, overrun}, 32'd0);

      // Signed wrap of the position across two back-to-back snaps.
      position = 32'h7FFF_FFF0; snap_req = 1;
      cyc();
      position = 32'h8000_0010;
      cyc();
      snap_req = 0;
      chk("wrap_pos", out_pos, 32'h8000_0010);
      chk("wrap_vel", out_vel, 32'd32);
      chk("wrap_count", {16'd0, sample_count}, 32'd7);

      // Snap while disabled, then no ticks for 50 cycles.
      enable = 0; position = 32'hFFFF_FFFB; snap_req = 1;
      cyc();
      snap_req = 0;
      chk("snapdis_pos", out_pos, 32'hFFFF_FFFB);
      chk("snapdis_count", {16'd0, sample_count}, 32'd8);
      cyc(50);
      chk("idle_count", {16'd0, sample_count}, 32'd8);
      chk("idle_valid", {31'd0, out_valid}, 32'd0);

      // Snap coinciding with the first tick after re-enable gives one sample.
      enable = 1; position = 50;
      cyc(7);
      snap_req = 1;
      cyc();
      snap_req = 0;
      chk("merge_pos", out_pos, 32'd50);
      chk("merge_vel", out_vel, 32'd0);
      chk("merge_count", {16'd0, sample_count}, 32'd9);
      cyc();
      chk("merge_count_after", {16'd0, sample_count}, 32'd9);

      // Reset while a sample is pending and overrun is set.
      enable = 0; out_ready = 0; snap_req = 1;
      cyc(2);
      snap_req = 0;
      chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
      chk("pre_rst_overrun", {31'd0, overrun}, 32'd1);
      rst = 1;
      model_reset();
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_pos", out_pos, 32'd0);
      chk("async_rst_count", {16'd0, sample_count}, 32'd0);
      chk("async_rst_overrun", {31'd0, overrun}, 32'd0);
      cyc(2);
      rst = 0;
      enable = 1; out_ready = 1;
      for (int k = 0; k < 12; k++) begin
         position = 32'(k * 3);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
